// File: rtl/serial2parallel.sv
// LSB-first serial-to-parallel receiver: frame starts with en, WIDTH bits follow; valid pulses WIDTH+1 cycles after en.
// No backpressure: a word is presented for one valid cycle, and data_out holds it until the next completion.
module serial2parallel #(
  parameter int WIDTH = 8,
  parameter int CTR_W = 3
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RECEIVE = 2'b01
  } state_t;

  localparam logic [CTR_W-1:0] LAST_BIT = CTR_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CTR_W-1:0] shiftctr, shiftctr_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] data_out_nxt;
  logic             valid_nxt;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= S_IDLE;
      shiftctr <= '0;
      shreg    <= '0;
      data_out <= '0;
      valid    <= 1'b0;
    end else begin
      state    <= state_nxt;
      shiftctr <= shiftctr_nxt;
      shreg    <= shreg_nxt;
      data_out <= data_out_nxt;
      valid    <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    shiftctr_nxt = shiftctr;
    shreg_nxt    = shreg;
    data_out_nxt = data_out;
    valid_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        shiftctr_nxt = '0;
        if (en) state_nxt = S_RECEIVE;
      end
      S_RECEIVE: begin
        // New bits enter at the MSB so the first one ends up in bit 0.
        shreg_nxt = {data_in, shreg[WIDTH-1:1]};
        if (shiftctr == LAST_BIT) begin
          data_out_nxt = shreg_nxt;
          valid_nxt    = 1'b1;
          state_nxt    = S_IDLE;
          shiftctr_nxt = '0;
        end else begin
          shiftctr_nxt = shiftctr + CTR_W'(1);
        end
      end
      default: begin
        state_nxt    = S_IDLE;
        shiftctr_nxt = '0;
      end
    endcase
  end

  assign busy = (state == S_RECEIVE);

endmodule

// File: tb/tb_serial2parallel.sv
// Randomised scoreboard bench for serial2parallel: a driver issues frames and queues the expected words,
// a negedge monitor pops and compares on every valid, and checks data_out/busy every cycle.
module tb_serial2parallel;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         en = 1'b0;
  logic         data_in = 1'b0;
  logic [W-1:0] data_out;
  logic         valid;
  logic         busy;

  serial2parallel #(.WIDTH(W), .CTR_W(3)) dut (
    .clk(clk), .nrst(nrst), .en(en), .data_in(data_in),
    .data_out(data_out), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] word;
    int           due;
  } exp_t;

  exp_t         q[$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  logic [W-1:0] exp_dout = '0;
  logic         exp_busy = 1'b0;
  logic         chk = 1'b0;
  logic         prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model for reset: a low nrst at an edge discards any pending frame and zeroes the word.
  always @(posedge clk) begin
    if (!nrst) begin
      q.delete();
      exp_dout = '0;
      chk = 1'b1;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (chk) begin
      if (valid) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_valid cycle %0d: got valid=1 with data_out %0h expected no word", cyc, data_out);
        end else begin
          exp_t e;
          e = q.pop_front();
          exp_dout = e.word;
          check("valid_cycle", cyc, e.due);
        end
      end
      if (q.size() > 0 && cyc > q[0].due) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_valid cycle %0d: got no valid expected word %0h at cycle %0d", cyc, q[0].word, q[0].due);
        exp_dout = q[0].word;
        void'(q.pop_front());
      end
      check("data_out", data_out, exp_dout);
      check("busy", busy, exp_busy);
      check("valid_pair", valid & prev_valid, 1'b0);
      prev_valid = valid;
    end
  end

  // One cycle of stimulus: inputs are applied just after an edge and held through the cycle.
  task automatic drive(input logic e, input logic d, input logic b, input logic r);
    en = e;
    data_in = d;
    exp_busy = b;
    nrst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] word, input logic [W-1:0] noise);
    exp_t e;
    e.word = word;
    e.due = cyc + W + 1;
    q.push_back(e);
    drive(1'b1, 1'($urandom), 1'b0, 1'b1);
    for (int k = 0; k < W; k++) drive(noise[k], word[k], 1'b1, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom), 1'b0, 1'b1);
  endtask

  initial begin
    logic [W-1:0] words[5];
    words = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h3C};

    // Reset held for three cycles with en and data_in toggling.
    for (int i = 0; i < 3; i++) drive(1'($urandom), 1'($urandom), 1'b0, 1'b0);
    idle(2);

    // Single frame, then hold.
    send_frame(8'hA5, 8'h00);
    idle(12);

    // Back-to-back frames.
    for (int i = 0; i < 5; i++) send_frame(words[i], 8'h00);
    idle(3);

    // en pulses mid-frame must be ignored (cycles 3 and 5 relative to en).
    send_frame(8'h5A, 8'b0001_0100);
    idle(3);

    // Reset mid-frame: bits 0..3 of 0xC3, nrst low during the fourth bit cycle.
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) drive(1'b0, 1'(8'hC3 >> k), 1'b1, 1'b1);
    drive(1'b0, 1'(8'hC3 >> 3), 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(8'h0F, 8'h00);
    idle(2);

    // Random frames with random en noise and random idle gaps (including none).
    for (int i = 0; i < 40; i++) begin
      send_frame(8'($urandom), 8'($urandom));
      idle($urandom_range(0, 3));
    end

    // Idle noise.
    idle(50);

    for (int i = 0; i < 100 && q.size() > 0; i++) idle(1);
    check("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
